// File: rtl/dmem_port_arbiter.sv
// Two-port round-robin arbiter onto a byte-wide data memory; serialises
// byte/half/word accesses into little-endian byte beats and acks once per access.
module dmem_port_arbiter #(
  parameter int noal = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            r0_req,
  input  logic            r0_we,
  input  logic [1:0]      r0_size,
  input  logic [noal-1:0] r0_addr,
  input  logic [31:0]     r0_wdata,
  output logic            r0_ack,
  output logic [31:0]     r0_rdata,
  input  logic            r1_req,
  input  logic            r1_we,
  input  logic [1:0]      r1_size,
  input  logic [noal-1:0] r1_addr,
  input  logic [31:0]     r1_wdata,
  output logic            r1_ack,
  output logic [31:0]     r1_rdata,
  output logic [noal-1:0] mem_addr,
  output logic [7:0]      mem_wdata,
  output logic            mem_we,
  output logic            mem_re,
  input  logic [7:0]      mem_rdata,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic [1:0]      beat_q, beat_d;
  logic [31:0]     buf_q, buf_d;
  logic            port_q, port_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic [noal-1:0] addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            last_beat;
  logic            in_xfer;
  logic            in_done;
  logic [31:0]     rd_out;

  always_comb begin
    last_beat = 1'b0;
    case (size_q)
      2'b00:   last_beat = (beat_q == 2'd0);
      2'b01:   last_beat = (beat_q == 2'd1);
      default: last_beat = (beat_q == 2'd3);
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    beat_d  = beat_q;
    buf_d   = buf_q;
    port_d  = port_q;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (r0_req || r1_req) begin
          // On a tie, last_q names the port served last, so the other one wins.
          port_d  = (r0_req && r1_req) ? ~last_q : r1_req;
          we_d    = port_d ? r1_we    : r0_we;
          size_d  = port_d ? r1_size  : r0_size;
          addr_d  = port_d ? r1_addr  : r0_addr;
          wdata_d = port_d ? r1_wdata : r0_wdata;
          last_d  = port_d;
          buf_d   = '0;
          beat_d  = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (!we_q) buf_d[{beat_q, 3'b000} +: 8] = mem_rdata;
        beat_d = beat_q + 2'd1;
        if (last_beat) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      beat_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      buf_q   <= buf_d;
    end
  end

  // Request fields are only observed under XFER/DONE, so they need no reset.
  always_ff @(posedge clk) begin
    port_q  <= port_d;
    we_q    <= we_d;
    size_q  <= size_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  always_comb begin
    in_xfer   = (state_q == XFER);
    in_done   = (state_q == DONE);
    busy      = (state_q != IDLE);
    mem_we    = in_xfer && we_q;
    mem_re    = in_xfer && !we_q;
    mem_addr  = in_xfer ? addr_q + noal'(beat_q) : '0;
    mem_wdata = mem_we ? wdata_q[{beat_q, 3'b000} +: 8] : '0;
    r0_ack    = in_done && !port_q;
    r1_ack    = in_done && port_q;
    rd_out    = (in_done && !we_q) ? buf_q : '0;
    r0_rdata  = r0_ack ? rd_out : '0;
    r1_rdata  = r1_ack ? rd_out : '0;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomised bench for dmem_port_arbiter against a transaction-level model
// of memory contents, beat sequence, latency and round-robin order.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
  logic [1:0]  r0_size = 0, r1_size = 0;
  logic [7:0]  r0_addr = 0, r1_addr = 0;
  logic [31:0] r0_wdata = 0, r1_wdata = 0;
  logic        r0_ack, r1_ack, mem_we, mem_re, busy;
  logic [31:0] r0_rdata, r1_rdata;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;

  logic [7:0]  tb_mem [256];
  logic [7:0]  ref_mem[256];
  bit          model_last;
  int          checks = 0;
  int          fails = 0;

  logic [7:0]  obs_addr[4];
  logic [7:0]  obs_data[4];
  int          obs_n;
  int          obs_ack_cyc;
  logic [31:0] obs_rd;
  bit          obs_bad;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.noal(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_size(r0_size), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_size(r1_size), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .busy(busy)
  );

  assign mem_rdata = tb_mem[mem_addr];
  always @(posedge clk) if (mem_we) tb_mem[mem_addr] <= mem_wdata;

  function automatic int nb(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [7:0] a, input logic [1:0] sz);
    logic [31:0] v = '0;
    for (int k = 0; k < nb(sz); k++) v[8*k +: 8] = ref_mem[a + 8'(k)];
    return v;
  endfunction

  function automatic void ref_write(input logic [7:0] a, input logic [1:0] sz,
                                    input logic [31:0] wd);
    for (int k = 0; k < nb(sz); k++) ref_mem[a + 8'(k)] = wd[8*k +: 8];
  endfunction

  // Drives one request on a single port and records what the memory side
  // and the ack show, cycle by cycle, until the ack or a cycle budget.
  task automatic xfer(input bit p, input bit we, input logic [1:0] sz,
                      input logic [7:0] a, input logic [31:0] wd);
    @(negedge clk);
    if (p) begin
      r1_req = 1; r1_we = we; r1_size = sz; r1_addr = a; r1_wdata = wd;
    end else begin
      r0_req = 1; r0_we = we; r0_size = sz; r0_addr = a; r0_wdata = wd;
    end
    obs_n = 0; obs_ack_cyc = -1; obs_bad = 0; obs_rd = 'x;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (mem_we || mem_re) begin
        if (obs_n < 4) begin
          obs_addr[obs_n] = mem_addr;
          obs_data[obs_n] = mem_we ? mem_wdata : mem_rdata;
        end
        if (mem_we && mem_re) obs_bad = 1;
        obs_n++;
      end
      if (p ? r0_ack : r1_ack) obs_bad = 1;
      if (p ? r1_ack : r0_ack) begin
        obs_ack_cyc = c;
        obs_rd = p ? r1_rdata : r0_rdata;
        break;
      end
    end
    r0_req = 0; r1_req = 0;
    model_last = p;
  endtask

  task automatic test_reset;
    r0_req = 1; r0_we = 0; r0_size = 2'b00; r0_addr = 8'h20;
    r1_req = 1; r1_we = 0; r1_size = 2'b00; r1_addr = 8'h21;
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, r0_ack, r1_ack, mem_we, mem_re, mem_addr, mem_wdata, r0_rdata, r1_rdata} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: busy=%b ack=%b%b we=%b re=%b addr=%h wd=%h rd0=%h rd1=%h, all required 0",
               busy, r0_ack, r1_ack, mem_we, mem_re, mem_addr, mem_wdata, r0_rdata, r1_rdata);
    end
    rst_n = 1;
    model_last = 1;
    obs_ack_cyc = -1;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (r0_ack || r1_ack) begin
        obs_ack_cyc = c;
        checks++;
        if ({r0_ack, r1_ack} !== 2'b10) begin
          fails++; $display("FAIL reset_first_grant: acks=%b required 10", {r0_ack, r1_ack});
        end
        checks++;
        if (r0_rdata !== exp_rd(8'h20, 2'b00)) begin
          fails++; $display("FAIL reset_first_rdata: got %h required %h", r0_rdata, exp_rd(8'h20, 2'b00));
        end
        break;
      end
    end
    r0_req = 0; r1_req = 0;
    model_last = 0;
    checks++;
    if (obs_ack_cyc != 2) begin
      fails++; $display("FAIL reset_first_latency: ack cycle %0d required 2", obs_ack_cyc);
    end
  endtask

  task automatic test_word_write;
    xfer(0, 1, 2'b10, 8'h10, 32'hDEADBEEF);
    ref_write(8'h10, 2'b10, 32'hDEADBEEF);
    checks++;
    if (obs_ack_cyc != 5 || obs_n != 4 || obs_bad) begin
      fails++; $display("FAIL ww_timing: ack cycle %0d beats %0d bad %0d, required 5/4/0", obs_ack_cyc, obs_n, obs_bad);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_addr[k] !== 8'h10 + 8'(k) || obs_data[k] !== 8'(32'hDEADBEEF >> (8*k))) begin
        fails++; $display("FAIL ww_beat%0d: got (%h,%h) required (%h,%h)", k, obs_addr[k], obs_data[k],
                          8'h10 + 8'(k), 8'(32'hDEADBEEF >> (8*k)));
      end
    end
    checks++;
    if (obs_rd !== 32'h0) begin
      fails++; $display("FAIL ww_rdata: got %h required 0", obs_rd);
    end
    @(negedge clk);
    checks++;
    if ({r0_ack, r1_ack, busy} !== 3'b000 || r0_rdata !== 32'h0) begin
      fails++; $display("FAIL ww_ack_one_cycle: ack=%b%b busy=%b rd=%h required 0", r0_ack, r1_ack, busy, r0_rdata);
    end
    checks++;
    if ({tb_mem[8'h13], tb_mem[8'h12], tb_mem[8'h11], tb_mem[8'h10]} !== exp_rd(8'h10, 2'b10)) begin
      fails++; $display("FAIL ww_memory: got %h required %h",
                        {tb_mem[8'h13], tb_mem[8'h12], tb_mem[8'h11], tb_mem[8'h10]}, exp_rd(8'h10, 2'b10));
    end
  endtask

  task automatic test_half_read;
    tb_mem[8'h02] = 8'h34; tb_mem[8'h03] = 8'h12;
    ref_mem[8'h02] = 8'h34; ref_mem[8'h03] = 8'h12;
    xfer(1, 0, 2'b01, 8'h02, $urandom);
    checks++;
    if (obs_ack_cyc != 3 || obs_n != 2 || obs_bad) begin
      fails++; $display("FAIL hr_timing: ack cycle %0d beats %0d bad %0d, required 3/2/0", obs_ack_cyc, obs_n, obs_bad);
    end
    checks++;
    if (obs_rd !== 32'h00001234) begin
      fails++; $display("FAIL hr_rdata: got %h required 00001234", obs_rd);
    end
    xfer(1, 0, 2'b00, 8'h03, $urandom);
    checks++;
    if (obs_ack_cyc != 2 || obs_rd !== 32'h00000012) begin
      fails++; $display("FAIL br_rdata: cycle %0d data %h required 2 / 00000012", obs_ack_cyc, obs_rd);
    end
  endtask

  task automatic test_wrap;
    logic [7:0] ea;
    xfer(1, 1, 2'b11, 8'hFE, 32'h04030201);
    ref_write(8'hFE, 2'b11, 32'h04030201);
    checks++;
    if (obs_ack_cyc != 5 || obs_n != 4) begin
      fails++; $display("FAIL wrap_timing: ack cycle %0d beats %0d required 5/4", obs_ack_cyc, obs_n);
    end
    for (int k = 0; k < 4; k++) begin
      ea = 8'hFE + 8'(k);
      checks++;
      if (obs_addr[k] !== ea || obs_data[k] !== 8'(k + 1)) begin
        fails++; $display("FAIL wrap_beat%0d: got (%h,%h) required (%h,%h)", k, obs_addr[k], obs_data[k], ea, 8'(k + 1));
      end
    end
  endtask

  task automatic test_round_robin;
    int  n_acks = 0;
    bit  first;
    bit  p;
    first = ~model_last;
    @(negedge clk);
    r0_req = 1; r0_we = 0; r0_size = 2'b10; r0_addr = 8'h80;
    r1_req = 1; r1_we = 0; r1_size = 2'b10; r1_addr = 8'h90;
    @(posedge clk);
    for (int c = 1; c <= 40 && n_acks < 4; c++) begin
      @(negedge clk);
      if (r0_ack || r1_ack) begin
        p = r1_ack;
        checks++;
        if (r0_ack && r1_ack) begin
          fails++; $display("FAIL rr_both_ack: cycle %0d both ports acked", c);
        end
        checks++;
        if (p !== (first ^ n_acks[0]) || c != 5 + 6 * n_acks) begin
          fails++; $display("FAIL rr_order%0d: port %0d at cycle %0d, required port %0d at cycle %0d",
                            n_acks, p, c, first ^ n_acks[0], 5 + 6 * n_acks);
        end
        checks++;
        if ((p ? r1_rdata : r0_rdata) !== exp_rd(p ? 8'h90 : 8'h80, 2'b10)) begin
          fails++; $display("FAIL rr_rdata%0d: got %h required %h", n_acks,
                            p ? r1_rdata : r0_rdata, exp_rd(p ? 8'h90 : 8'h80, 2'b10));
        end
        model_last = p;
        n_acks++;
      end
    end
    r0_req = 0; r1_req = 0;
    checks++;
    if (n_acks != 4) begin
      fails++; $display("FAIL rr_count: %0d acks seen, required 4", n_acks);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] wd;
    logic [31:0] got;
    wd = {ref_mem[8'h43], ref_mem[8'h42], 8'($urandom), 8'($urandom)};
    @(negedge clk);
    r0_req = 1; r0_we = 1; r0_size = 2'b10; r0_addr = 8'h40; r0_wdata = wd;
    @(posedge clk);
    repeat (3) @(negedge clk);
    rst_n = 0; r0_req = 0;
    @(negedge clk);
    checks++;
    if ({busy, r0_ack, r1_ack, mem_we, mem_re} !== 5'b0) begin
      fails++; $display("FAIL rm_abort: busy=%b ack=%b%b we=%b re=%b required 0", busy, r0_ack, r1_ack, mem_we, mem_re);
    end
    rst_n = 1;
    model_last = 1;
    ref_write(8'h40, 2'b01, wd);
    got = {tb_mem[8'h43], tb_mem[8'h42], tb_mem[8'h41], tb_mem[8'h40]};
    checks++;
    if (got !== exp_rd(8'h40, 2'b10)) begin
      fails++; $display("FAIL rm_partial: memory %h required %h", got, exp_rd(8'h40, 2'b10));
    end
    xfer(1, 0, 2'b10, 8'h40, 32'h0);
    checks++;
    if (obs_ack_cyc != 5 || obs_rd !== exp_rd(8'h40, 2'b10)) begin
      fails++; $display("FAIL rm_fresh: cycle %0d data %h required 5 / %h", obs_ack_cyc, obs_rd, exp_rd(8'h40, 2'b10));
    end
  endtask

  task automatic test_random;
    bit          p, we;
    logic [1:0]  sz;
    logic [7:0]  a;
    logic [31:0] wd, exp;
    int          n;
    for (int i = 0; i < 24; i++) begin
      p  = 1'($urandom);
      we = 1'($urandom);
      sz = 2'($urandom);
      a  = 8'($urandom);
      wd = $urandom;
      n  = nb(sz);
      exp = we ? 32'h0 : exp_rd(a, sz);
      xfer(p, we, sz, a, wd);
      checks++;
      if (obs_ack_cyc != n + 1 || obs_n != n || obs_bad) begin
        fails++; $display("FAIL rnd%0d_timing: ack cycle %0d beats %0d bad %0d, required %0d/%0d/0",
                          i, obs_ack_cyc, obs_n, obs_bad, n + 1, n);
      end
      for (int k = 0; k < n && k < obs_n; k++) begin
        checks++;
        if (obs_addr[k] !== a + 8'(k) ||
            obs_data[k] !== (we ? wd[8*k +: 8] : ref_mem[a + 8'(k)])) begin
          fails++; $display("FAIL rnd%0d_beat%0d: got (%h,%h) required (%h,%h)", i, k, obs_addr[k], obs_data[k],
                            a + 8'(k), we ? wd[8*k +: 8] : ref_mem[a + 8'(k)]);
        end
      end
      checks++;
      if (obs_rd !== exp) begin
        fails++; $display("FAIL rnd%0d_rdata: got %h required %h", i, obs_rd, exp);
      end
      if (we) ref_write(a, sz, wd);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = 8'($urandom);
      ref_mem[i] = tb_mem[i];
    end
    test_reset;
    test_word_write;
    test_half_read;
    test_wrap;
    test_round_robin;
    test_reset_mid;
    test_random;
    test_round_robin;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Arbitrates a byte-wide data-memory port between two 32-bit requesters: the core load/store unit on port 0 and the program/debug loader on port 1. Each granted access is byte, halfword or word sized. The block serialises it into 1, 2 or 4 little-endian byte beats on the memory side. It returns a single-cycle acknowledge with zero-extended read data. It sits between the core/loader and the 8-bit-per-location data memory, which has combinational reads.

## Interface
- noal, 8, number of memory address lines (2**noal byte locations)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- r0_req  in  1  port 0 request; held high until r0_ack
- r0_we  in  1  port 0 write (1) / read (0)
- r0_size  in  2  00 byte, 01 halfword, 10/11 word
- r0_addr  in  noal  port 0 byte base address
- r0_wdata  in  32  port 0 write data, little-endian
- r0_ack  out  1  one-cycle completion pulse
- r0_rdata  out  32  zero-extended read data, valid while r0_ack=1
- r1_req, r1_we, r1_size, r1_addr, r1_wdata, r1_ack, r1_rdata: same as port 0, for port 1
- mem_addr  out  noal  byte address to memory
- mem_wdata  out  8  byte to write
- mem_we  out  1  byte write strobe
- mem_re  out  1  byte read strobe
- mem_rdata  in  8  byte read data, combinational from mem_addr
- busy  out  1  high when state is not IDLE

## Operation
- States: IDLE, XFER, DONE.
- **IDLE**
  - With no request, stay in IDLE.
  - With exactly one request, grant that port.
  - With both requesting, grant the port not granted last (round robin). The last-grant pointer resets to 1, so port 0 wins the first tie.
  - On grant: latch we, size, addr and wdata; update the last-grant pointer; clear the rdata buffer and beat counter; go to XFER.
- **XFER**
  - Beat count n = 1, 2 or 4 by latched size.
  - On beat k (0..n-1): mem_addr = (addr + k) mod 2**noal, so addresses wrap with no alignment check.
  - Write: mem_we=1, mem_wdata=wdata[8k+7:8k].
  - Read: mem_re=1, and mem_rdata is captured into buffer byte lane k at the clock edge.
  - After beat n-1, go to DONE.
- **DONE**
  - The granted port's ack=1 and rdata = buffer; upper lanes stay 0 for byte/half reads.
  - For writes, rdata = 0.
  - Next state is IDLE.
- The other port is never acked while a transfer is in flight. Its request waits in IDLE arbitration.
- Requester inputs are ignored after grant. Dropping req mid-transfer does not abort the transfer, and ack is still issued.
- A request still high in the cycle after its ack counts as a new request.
- Outside XFER: mem_we=mem_re=0, mem_addr=0, mem_wdata=0.

## Timing
- Reset (rst_n low at a rising edge):
  - state goes to IDLE, last-grant goes to 1, beat counter and buffer clear to 0.
  - busy, r0_ack, r1_ack, mem_we and mem_re all go to 0.
  - mem_addr, mem_wdata, r0_rdata and r1_rdata all go to 0.
- Reset mid-XFER aborts immediately with no ack. Bytes already written stay in memory (a partial write is allowed).
- Latency: request sampled in IDLE at cycle 0; beats in cycles 1..n; ack in cycle n+1.
  - Byte access: ack in cycle 2.
  - Halfword access: ack in cycle 3.
  - Word access: ack in cycle 5.
- Back-to-back: the earliest next grant is the IDLE cycle after DONE, so at most one transfer per n+2 cycles.
- Both the ack pulse and the rdata it qualifies last exactly one cycle.
- All outputs are registered or decoded from state/latched fields only. There is no combinational path from req to mem_*.

## Test plan
- Reset: assert rst_n=0 for 2 cycles with both reqs high -> every output is 0 and busy=0. After release, port 0 is granted first.
- Port 0 word write of 32'hDEADBEEF at 8'h10 -> cycles 1-4 drive mem_we=1 with (10,EF), (11,BE), (12,AD), (13,DE). r0_ack=1 in cycle 5 only.
- Port 1 halfword read at 8'h02, memory bytes [02]=34, [03]=12 -> r1_ack in cycle 3 with r1_rdata=32'h00001234. A byte read of 8'h03 returns 32'h00000012.
- Both ports request word reads continuously -> grants alternate 0,1,0,1. Acks come every 6 cycles, never both in the same cycle.
- Word write of 32'h04030201 at 8'hFE -> beats drive addresses FE, FF, 00, 01 with bytes 01, 02, 03, 04.
- rst_n=0 during beat 2 of a word write -> no ack, busy=0 on the next cycle. Bytes from beats 0-1 remain in memory and a fresh request is accepted normally.
